// File: rtl/xbar_rr_allocator.sv
// Packet-level switch allocator: one round-robin arbiter per output that locks
// onto the winning input from head to tail flit and drives the crossbar select.
module xbar_rr_allocator #(
    parameter int IN_N  = 5,
    parameter int OUT_M = 5,
    parameter int SEL_W = $clog2(IN_N)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [IN_N-1:0]               req_vld_i,
    input  logic [IN_N*$clog2(OUT_M)-1:0] req_dst_i,
    input  logic [IN_N-1:0]               req_last_i,
    input  logic [OUT_M-1:0]              out_rdy_i,
    output logic [OUT_M*SEL_W-1:0]        sel_o,
    output logic [OUT_M-1:0]              out_vld_o,
    output logic [IN_N-1:0]               gnt_o
);

    localparam int DST_W = $clog2(OUT_M);
    localparam int unsigned N_IN = IN_N;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    logic [DST_W-1:0]             w_dst [IN_N];
    logic [OUT_M-1:0][IN_N-1:0]   w_gnt_all;

    for (genvar gi = 0; gi < IN_N; gi++) begin : g_dst
        assign w_dst[gi] = req_dst_i[gi*DST_W +: DST_W];
    end

    for (genvar mo = 0; mo < OUT_M; mo++) begin : g_out
        localparam logic [DST_W-1:0] MO = DST_W'(mo);

        state_t           r_state;
        state_t           w_state_nxt;
        logic [SEL_W-1:0] r_owner;
        logic [SEL_W-1:0] r_ptr;
        logic [SEL_W-1:0] w_owner_nxt;
        logic [SEL_W-1:0] w_ptr_nxt;
        logic [SEL_W-1:0] w_win;
        logic             w_found;
        logic [IN_N-1:0]  w_cand;
        logic [IN_N-1:0]  w_gnt_m;
        logic             w_xfer;

        always_comb begin
            for (int unsigned gi = 0; gi < N_IN; gi++) begin
                w_cand[gi] = req_vld_i[gi] && (w_dst[gi] == MO);
            end
        end

        // Priority rotate: scan candidates starting at the pointer, wrapping at IN_N.
        always_comb begin
            int unsigned idx;
            w_found = 1'b0;
            w_win   = '0;
            idx     = 0;
            for (int unsigned k = 0; k < N_IN; k++) begin
                idx = (32'(r_ptr) + k) % N_IN;
                if (!w_found && w_cand[idx]) begin
                    w_found = 1'b1;
                    w_win   = SEL_W'(idx);
                end
            end
        end

        assign w_xfer = (r_state == S_BUSY) && req_vld_i[r_owner]
                        && (w_dst[r_owner] == MO) && out_rdy_i[mo];

        always_comb begin
            w_state_nxt = r_state;
            w_owner_nxt = r_owner;
            w_ptr_nxt   = r_ptr;
            w_gnt_m     = '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        w_state_nxt = S_BUSY;
                        w_owner_nxt = w_win;
                    end
                end
                S_BUSY: begin
                    w_gnt_m[r_owner] = w_xfer;
                    if (w_xfer && req_last_i[r_owner]) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = (r_owner == SEL_W'(IN_N-1)) ? '0 : r_owner + 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= S_IDLE;
                r_owner <= '0;
                r_ptr   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_owner <= w_owner_nxt;
                r_ptr   <= w_ptr_nxt;
            end
        end

        assign w_gnt_all[mo]               = w_gnt_m;
        assign out_vld_o[mo]               = w_xfer;
        assign sel_o[mo*SEL_W +: SEL_W]    = r_owner;
    end

    // An input presents one destination at a time, so at most one term per bit is set.
    always_comb begin
        gnt_o = '0;
        for (int unsigned m = 0; m < OUT_M; m++) begin
            gnt_o = gnt_o | w_gnt_all[m];
        end
    end

endmodule
